// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the RV32I width codes, the FSM encoding and the default memory depth.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_WORDS_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_lane_extract.sv
// Selects the addressed byte/halfword of a memory word and sign/zero extends it.
// Purely combinational so the forwarding path can reuse it.
module load_store_unit_lane_extract
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_B:    o_value = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_value = {24'h0, w_byte};
      F3_H:    o_value = {{16{w_half[15]}}, w_half};
      F3_HU:   o_value = {16'h0, w_half};
      default: o_value = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for a word-addressed data memory: RV32I loads/stores,
// with read-modify-write for byte/halfword stores and fault detection.
//
// state | meaning
// IDLE  | accepting requests; loads and SW complete in one cycle
// MERGE | second cycle of SB/SH: write back the captured word with lane replaced
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              access_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

  lsu_state_t r_state;
  lsu_state_t w_state_nxt;

  logic [31:0]       r_word;
  logic [1:0]        r_lane;
  logic              r_half;
  logic [15:0]       r_sdata;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_load_data;
  logic              r_load_valid;
  logic              r_fault;

  logic              w_f3_ok;
  logic              w_align_ok;
  logic              w_range_ok;
  logic              w_legal;
  logic [ADDR_W-1:0] w_word_addr;
  logic [31:0]       w_ext;
  logic [31:0]       w_merged;

  assign w_word_addr = {2'b00, addr[ADDR_W-1:2]};

  // Unsigned widths are stores-only restricted: SBU/SHU do not exist
  always_comb begin
    case (funct3)
      F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
      F3_BU, F3_HU:     w_f3_ok = !req_write;
      default:          w_f3_ok = 1'b0;
    endcase
  end

  assign w_align_ok = (funct3[1:0] == 2'b01) ? !addr[0] :
                      (funct3[1:0] == 2'b10) ? (addr[1:0] == 2'b00) : 1'b1;
  assign w_range_ok = {1'b0, addr} < ADDR_LIMIT;
  assign w_legal    = w_f3_ok && w_align_ok && w_range_ok;

  load_store_unit_lane_extract u_lane_extract (
    .i_word   (mem_rdata),
    .i_offset (addr[1:0]),
    .i_funct3 (funct3),
    .o_value  (w_ext)
  );

  always_comb begin
    w_merged = r_word;
    if (r_half) begin
      if (r_lane[1]) w_merged[31:16] = r_sdata;
      else           w_merged[15:0]  = r_sdata;
    end else begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_sdata[7:0];
        2'd1:    w_merged[15:8]  = r_sdata[7:0];
        2'd2:    w_merged[23:16] = r_sdata[7:0];
        default: w_merged[31:24] = r_sdata[7:0];
      endcase
    end
  end

  // Memory strobes are forced low during reset so an abandoned merge never writes
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = 32'h0;
    mem_addr    = w_word_addr;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (req_valid && w_legal) begin
            if (!req_write) begin
              mem_read = 1'b1;
            end else if (funct3 == F3_W) begin
              mem_write = 1'b1;
              mem_wdata = store_data;
            end else begin
              mem_read    = 1'b1;
              stall       = 1'b1;
              w_state_nxt = MERGE;
            end
          end
        end
        MERGE: begin
          mem_write   = 1'b1;
          mem_wdata   = w_merged;
          mem_addr    = r_addr;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word       <= 32'h0;
      r_lane       <= 2'd0;
      r_half       <= 1'b0;
      r_sdata      <= 16'h0;
      r_addr       <= '0;
      r_load_data  <= 32'h0;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
      if (r_state == IDLE && req_valid) begin
        if (!w_legal) begin
          r_fault <= 1'b1;
        end else if (!req_write) begin
          r_load_valid <= 1'b1;
          r_load_data  <= w_ext;
        end else if (funct3 != F3_W) begin
          r_word  <= mem_rdata;
          r_lane  <= addr[1:0];
          r_half  <= funct3[0];
          r_sdata <= store_data[15:0];
          r_addr  <= w_word_addr;
        end
      end
    end
  end

  assign load_data    = r_load_data;
  assign load_valid   = r_load_valid;
  assign access_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-MERGE sequence and
// randomized requests checked against an arithmetic memory/lane model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, access_fault, mem_read, mem_write;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.MEM_WORDS(64), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .access_fault (access_fault),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory served to the DUT
  logic [31:0] mem [64];
  always @(posedge clk) if (mem_write && mem_addr < 64) mem[mem_addr[5:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < 64) ? mem[mem_addr[5:0]] : 32'h0;

  // Reference model state
  bit [31:0]   ref_mem [64];
  logic [31:0] ld_hold;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] a;
    bit [31:0] sd;
    bit        fault;
    bit [31:0] val;
    string     name;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int m_size(input bit [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input bit wr, input bit [2:0] f3, input bit [31:0] a);
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    if (wr && f3 > 3'b010) return 1'b0;
    if (a % m_size(f3) != 0) return 1'b0;
    return a < 256;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a);
    bit [31:0] v;
    int        sz;
    sz = m_size(f3);
    v  = ref_mem[a / 4] >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic bit [31:0] m_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd);
    bit [31:0] mask;
    int        sh;
    mask = (m_size(f3) == 1) ? 32'hFF : (m_size(f3) == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    sh   = 8 * (a % 4);
    return (ref_mem[a / 4] & ~(mask << sh)) | ((sd & mask) << sh);
  endfunction

  // Drives one request at a negedge; returns at the negedge after it completes.
  task automatic run(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd,
                     input bit e_fault, input bit [31:0] e_val, input string tag);
    bit sub;
    sub = wr && !e_fault && (f3 != 3'b010);
    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; store_data = sd;
    #1;
    chk({tag, " mem_addr"}, mem_addr, a >> 2);
    if (e_fault) begin
      chk({tag, " mem_read"}, mem_read, 0);
      chk({tag, " mem_write"}, mem_write, 0);
      chk({tag, " stall"}, stall, 0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
    end else if (!wr) begin
      chk({tag, " mem_read"}, mem_read, 1);
      chk({tag, " mem_write"}, mem_write, 0);
      chk({tag, " stall"}, stall, 0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
    end else if (!sub) begin
      chk({tag, " mem_read"}, mem_read, 0);
      chk({tag, " mem_write"}, mem_write, 1);
      chk({tag, " stall"}, stall, 0);
      chk({tag, " mem_wdata"}, mem_wdata, e_val);
    end else begin
      chk({tag, " mem_read c0"}, mem_read, 1);
      chk({tag, " mem_write c0"}, mem_write, 0);
      chk({tag, " stall c0"}, stall, 1);
      chk({tag, " mem_wdata c0"}, mem_wdata, 0);
    end
    @(posedge clk); @(negedge clk);
    if (sub) begin
      // Inputs are ignored in the merge cycle; present garbage
      req_valid = 1'($urandom); req_write = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; store_data = $urandom;
      #1;
      chk({tag, " mem_write c1"}, mem_write, 1);
      chk({tag, " mem_read c1"}, mem_read, 0);
      chk({tag, " stall c1"}, stall, 0);
      chk({tag, " mem_addr c1"}, mem_addr, a >> 2);
      chk({tag, " mem_wdata c1"}, mem_wdata, e_val);
      chk({tag, " load_valid c1"}, load_valid, 0);
      chk({tag, " fault c1"}, access_fault, 0);
      @(posedge clk); @(negedge clk);
    end
    req_valid = 1'b0;
    chk({tag, " access_fault"}, access_fault, 32'(e_fault));
    chk({tag, " load_valid"}, load_valid, 32'(!wr && !e_fault));
    if (!wr && !e_fault) ld_hold = e_val;
    chk({tag, " load_data"}, load_data, ld_hold);
    if (wr && !e_fault) ref_mem[a[7:2]] = e_val;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_write = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom_range(0, 255); store_data = $urandom;
    #1;
    chk("idle mem_read", mem_read, 0);
    chk("idle mem_write", mem_write, 0);
    chk("idle stall", stall, 0);
    @(posedge clk); @(negedge clk);
    chk("idle load_valid", load_valid, 0);
    chk("idle access_fault", access_fault, 0);
    chk("idle load_data", load_data, ld_hold);
  endtask

  initial begin
    bit [31:0] w, a, sd, ev;
    bit [2:0]  f3;
    bit        wr, lg;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b0;
    addr = 32'h0; store_data = 32'h0; ld_hold = 32'h0;
    @(negedge clk);
    chk("reset load_data", load_data, 0);
    chk("reset load_valid", load_valid, 0);
    chk("reset access_fault", access_fault, 0);
    chk("reset stall", stall, 0);
    chk("reset mem_read", mem_read, 0);
    chk("reset mem_write", mem_write, 0);
    @(negedge clk);
    reset = 1'b0;

    // Preload memory through SW
    for (int i = 0; i < 64; i++) begin
      w = (i == 3) ? 32'h80FF7F01 : (i == 4) ? 32'hDEADBEEF : (i == 63) ? 32'h13579BDF : $urandom;
      run(1'b1, 3'b010, 32'(i * 4), w, 1'b0, w, "preload SW");
    end

    vecs.push_back('{1'b0, 3'd0, 32'h0E,  32'h0,        1'b0, 32'hFFFFFFFF, "LB 0x0E"});
    vecs.push_back('{1'b0, 3'd4, 32'h0E,  32'h0,        1'b0, 32'h000000FF, "LBU 0x0E"});
    vecs.push_back('{1'b0, 3'd1, 32'h0E,  32'h0,        1'b0, 32'hFFFF80FF, "LH 0x0E"});
    vecs.push_back('{1'b0, 3'd5, 32'h0C,  32'h0,        1'b0, 32'h00007F01, "LHU 0x0C"});
    vecs.push_back('{1'b0, 3'd0, 32'h0D,  32'h0,        1'b0, 32'h0000007F, "LB 0x0D"});
    vecs.push_back('{1'b0, 3'd1, 32'h0C,  32'h0,        1'b0, 32'h00007F01, "LH 0x0C"});
    vecs.push_back('{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, "SW 0x10"});
    vecs.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, "LW 0x10"});
    vecs.push_back('{1'b1, 3'd0, 32'h11,  32'h00000012, 1'b0, 32'hDEAD12EF, "SB 0x11"});
    vecs.push_back('{1'b1, 3'd1, 32'h12,  32'h0000AAAA, 1'b0, 32'hAAAA12EF, "SH 0x12"});
    vecs.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hAAAA12EF, "LW after merge"});
    vecs.push_back('{1'b1, 3'd0, 32'h13,  32'hFFFFFF77, 1'b0, 32'h77AA12EF, "SB 0x13"});
    vecs.push_back('{1'b0, 3'd4, 32'hFF,  32'h0,        1'b0, 32'h00000013, "LBU 0xFF top"});
    vecs.push_back('{1'b0, 3'd2, 32'h02,  32'h0,        1'b1, 32'h0,        "LW 0x02 misaligned"});
    vecs.push_back('{1'b1, 3'd1, 32'h01,  32'h00001234, 1'b1, 32'h0,        "SH 0x01 misaligned"});
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        1'b1, 32'h0,        "LW 0x100 range"});
    vecs.push_back('{1'b0, 3'd0, 32'h100, 32'h0,        1'b1, 32'h0,        "LB 0x100 range"});
    vecs.push_back('{1'b0, 3'd3, 32'h00,  32'h0,        1'b1, 32'h0,        "load f3 011"});
    vecs.push_back('{1'b1, 3'd4, 32'h00,  32'h00000055, 1'b1, 32'h0,        "store f3 100"});
    vecs.push_back('{1'b0, 3'd6, 32'h04,  32'h0,        1'b1, 32'h0,        "load f3 110"});

    foreach (vecs[i])
      run(vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].sd, vecs[i].fault, vecs[i].val, vecs[i].name);

    // Reset raised during MERGE abandons the write
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b000; addr = 32'h20; store_data = 32'h5A;
    #1;
    chk("rst-merge stall c0", stall, 1);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst-merge mem_write", mem_write, 0);
    chk("rst-merge mem_read", mem_read, 0);
    chk("rst-merge stall", stall, 0);
    chk("rst-merge load_valid", load_valid, 0);
    chk("rst-merge access_fault", access_fault, 0);
    chk("rst-merge load_data", load_data, 0);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst-merge mem word 8", mem[8], ref_mem[8]);
    reset = 1'b0;
    ld_hold = 32'h0;
    run(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, ref_mem[8], "LW 0x20 after reset");

    // Randomized requests against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
      end else begin
        wr = 1'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        case ($urandom_range(0, 19))
          0:       a = $urandom;
          1:       a = $urandom_range(256, 300);
          default: a = $urandom_range(0, 255);
        endcase
        if ($urandom_range(0, 2) != 0) a = a & ~(32'(m_size(f3)) - 32'd1);
        sd = $urandom;
        lg = m_legal(wr, f3, a);
        ev = !lg ? 32'h0 : wr ? m_store(f3, a, sd) : m_load(f3, a);
        run(wr, f3, a, sd, !lg, ev, "random");
      end
    end

    for (int i = 0; i < 64; i++) chk("final mem word", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
